// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX among NUM_REQ byte producers, one byte per grant.
// Optional UART_ARB_TAG_EN: each grant sends a tag byte (8'hA0 | grant_id) before the data byte.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 3,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 uart_start,
  output logic [7:0]           uart_data,
  input  logic                 uart_busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 arb_busy,
  output logic                 tx_error
);

  // state | meaning
  // IDLE  | waiting for a request, grant on |req
  // START | pulse uart_start, clear timeout counter
  // SEND  | waiting for uart_busy to rise, abort on timeout
  // WAIT  | waiting for uart_busy to fall (transfer done)
  typedef enum logic [1:0] {IDLE, START, SEND, WAIT} state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               start_q;
  logic [7:0]         uart_data_q;
  logic [ID_W-1:0]    grant_q;
  logic [ID_W-1:0]    ptr_q;
  logic               arb_busy_q;
  logic               tx_error_q;
  logic [7:0]         cnt_q;
`ifdef UART_ARB_TAG_EN
  logic [7:0]         data_q;
  logic               tag_phase_q;
`endif

  logic               win_valid;
  logic [ID_W-1:0]    win_id;
  logic [7:0]         win_data;

  // Scan from ptr+NUM_REQ down to ptr+1 so the smallest offset is assigned last and wins.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    win_data  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (req[idx]) begin
        win_valid = 1'b1;
        win_id    = ID_W'(idx);
        win_data  = req_data[8*idx +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ack_q       <= '0;
      start_q     <= 1'b0;
      uart_data_q <= '0;
      grant_q     <= '0;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      arb_busy_q  <= 1'b0;
      tx_error_q  <= 1'b0;
      cnt_q       <= '0;
`ifdef UART_ARB_TAG_EN
      data_q      <= '0;
      tag_phase_q <= 1'b0;
`endif
    end else begin
      ack_q      <= '0;
      start_q    <= 1'b0;
      tx_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_valid) begin
`ifdef UART_ARB_TAG_EN
            uart_data_q <= 8'hA0 | 8'(win_id);
            data_q      <= win_data;
            tag_phase_q <= 1'b1;
`else
            uart_data_q <= win_data;
`endif
            ack_q      <= NUM_REQ'(1) << win_id;
            grant_q    <= win_id;
            ptr_q      <= win_id;
            arb_busy_q <= 1'b1;
            state_q    <= START;
          end
        end
        START: begin
          start_q <= 1'b1;
          cnt_q   <= '0;
          state_q <= SEND;
        end
        SEND: begin
          if (uart_busy) begin
            state_q <= WAIT;
          end else if (cnt_q == 8'(BUSY_TIMEOUT - 1)) begin
            tx_error_q <= 1'b1;
            arb_busy_q <= 1'b0;
            state_q    <= IDLE;
`ifdef UART_ARB_TAG_EN
            tag_phase_q <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        WAIT: begin
          if (!uart_busy) begin
`ifdef UART_ARB_TAG_EN
            if (tag_phase_q) begin
              uart_data_q <= data_q;
              tag_phase_q <= 1'b0;
              state_q     <= START;
            end else begin
              arb_busy_q <= 1'b0;
              state_q    <= IDLE;
            end
`else
            arb_busy_q <= 1'b0;
            state_q    <= IDLE;
`endif
          end
        end
        default: begin
          arb_busy_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign ack        = ack_q;
  assign uart_start = start_q;
  assign uart_data  = uart_data_q;
  assign grant_id   = grant_q;
  assign arb_busy   = arb_busy_q;
  assign tx_error   = tx_error_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART_TX busy model and auto-dropping requesters.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
`ifdef UART_ARB_TAG_EN
  localparam int BPG = 2;
`else
  localparam int BPG = 1;
`endif
  localparam int DOFF = BPG - 1;

  logic          clock, reset;
  logic [NR-1:0] req_hold, drop_mask, req;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] ack;
  logic          uart_start;
  logic [7:0]    uart_data;
  logic          uart_busy;
  logic [2:0]    grant_id;
  logic          arb_busy, tx_error;

  int   n_cmp = 0, n_err = 0;
  int   busy_len = 10, busy_left = 0;
  bit   stall = 0, auto_drop = 0;
  logic [7:0] sent[$];
  int   ack_cnt[NR];
  int   dbl = 0;
  logic [NR-1:0] prev_ack;

  assign req = req_hold & ~drop_mask;

  uart_tx_arbiter #(.NUM_REQ(NR), .ID_W(3), .BUSY_TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .uart_start(uart_start), .uart_data(uart_data), .uart_busy(uart_busy),
    .grant_id(grant_id), .arb_busy(arb_busy), .tx_error(tx_error));

  initial begin clock = 0; forever #5 clock = ~clock; end

  // UART_TX model, requester drop-on-ack and ack monitor.
  initial begin
    uart_busy = 0; drop_mask = '0; prev_ack = '0;
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        uart_busy = 0; busy_left = 0; drop_mask = '0; prev_ack = '0;
        sent.delete(); dbl = 0;
        for (int i = 0; i < NR; i++) ack_cnt[i] = 0;
      end else begin
        #1;
        for (int i = 0; i < NR; i++) begin
          if (ack[i]) ack_cnt[i]++;
          if (ack[i] && prev_ack[i]) dbl++;
          if (ack[i] && auto_drop) drop_mask[i] = 1'b1;
        end
        prev_ack = ack;
        if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) uart_busy = 0;
        end
        if (uart_start && !stall) begin
          sent.push_back(uart_data);
          uart_busy = 1; busy_left = busy_len;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    req_hold = '0; #2; reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && arb_busy; i++) tick();
    check(tag, {31'd0, arb_busy}, 32'd0);
  endtask

  task automatic wait_sent(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && sent.size() < n; i++) tick();
    check(tag, sent.size(), n);
  endtask

  int n;

  initial begin
    reset = 1; req_hold = '0; req_data = '0;
    tick(); tick(); reset = 0;
    check("rst_ack", {28'd0, ack}, 0);
    check("rst_start", {31'd0, uart_start}, 0);
    check("rst_data", {24'd0, uart_data}, 0);
    check("rst_gid", {29'd0, grant_id}, 0);
    check("rst_busy", {31'd0, arb_busy}, 0);
    check("rst_err", {31'd0, tx_error}, 0);

    // single request, latency and transfer length
    busy_len = 10;
    req_data = 32'h0000_5A00; req_hold = 4'b0010;
    tick();
    check("t1_ack", {28'd0, ack}, 32'h2);
    check("t1_gid", {29'd0, grant_id}, 1);
    check("t1_start_early", {31'd0, uart_start}, 0);
    req_hold = '0;
    tick();
    check("t1_start", {31'd0, uart_start}, 1);
    check("t1_data", {24'd0, uart_data}, (BPG == 2) ? 32'hA1 : 32'h5A);
    check("t1_ack_pulse", {28'd0, ack}, 0);
    n = 0;
    while (arb_busy && n < 100) begin tick(); n++; end
    check("t1_cycles", n, (BPG == 2) ? 23 : 11);
    check("t1_gid_end", {29'd0, grant_id}, 1);
    check("t1_sent", {24'd0, sent[DOFF]}, 32'h5A);

    // all requests held: rotation 0,1,2,3,0
    do_reset();
    busy_len = 3; auto_drop = 0;
    req_data = 32'h3322_1100; req_hold = 4'b1111;
    wait_sent("t2_count", 5*BPG, 200);
    req_hold = '0;
    wait_idle("t2_idle", 50);
    for (int k = 0; k < 5; k++)
      check($sformatf("t2_byte%0d", k), {24'd0, sent[k*BPG+DOFF]}, (k % 4) * 32'h11);
    check("t2_ack0", ack_cnt[0], 2);
    check("t2_ack3", ack_cnt[3], 1);
    check("t2_single_pulse", dbl, 0);

    // req[0] and req[3] after reset
    do_reset();
    auto_drop = 1;
    req_data = 32'hBB00_00AA; req_hold = 4'b1001;
    wait_sent("t3_count", 2*BPG, 200);
    wait_idle("t3_idle", 50);
    check("t3_first", {24'd0, sent[DOFF]}, 32'hAA);
    check("t3_second", {24'd0, sent[BPG+DOFF]}, 32'hBB);

    // busy tied low: timeout, then next pending req granted
    do_reset();
    stall = 1;
    req_data = 32'h0044_0077; req_hold = 4'b0001;
    tick(); tick();
    check("t4_start", {31'd0, uart_start}, 1);
    req_hold = 4'b0101;
    n = 0;
    while (!tx_error && n < 40) begin tick(); n++; end
    check("t4_err_delay", n, 15);
    check("t4_idle", {31'd0, arb_busy}, 0);
    tick();
    check("t4_err_pulse", {31'd0, tx_error}, 0);
    check("t4_next_ack", {28'd0, ack}, 32'h4);
    check("t4_next_gid", {29'd0, grant_id}, 2);
    stall = 0;

    // reset in WAIT
    do_reset();
    auto_drop = 0; busy_len = 20;
    req_data = 32'h0000_5A00; req_hold = 4'b0010;
    for (int i = 0; i < 5; i++) tick();
    check("t5_in_wait", {31'd0, arb_busy}, 1);
    #2 reset = 1;
    #1;
    check("t5_rst_start", {31'd0, uart_start}, 0);
    check("t5_rst_busy", {31'd0, arb_busy}, 0);
    #1 reset = 0;
    tick();
    check("t5_regrant", {28'd0, ack}, 32'h2);

`ifdef UART_ARB_TAG_EN
    do_reset();
    auto_drop = 1; busy_len = 4;
    req_data = 32'h003C_0000; req_hold = 4'b0100;
    wait_sent("t6_count", 2, 100);
    wait_idle("t6_idle", 50);
    check("t6_tag", {24'd0, sent[0]}, 32'hA2);
    check("t6_data", {24'd0, sent[1]}, 32'h3C);
    check("t6_acks", ack_cnt[2], 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
